// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load handshake (load_valid/load_ready/din) and serial output (q/frame/done) of the PISO transmitter
interface piso_shift_tx_if #(parameter int WIDTH = 8);
  logic load_valid;
  logic load_ready;
  logic [WIDTH-1:0] din;
  logic q;
  logic frame;
  logic done;
  modport master (output load_valid, din, input load_ready, q, frame, done);
  modport slave (input load_valid, din, output load_ready, q, frame, done);
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: MSB-first PISO transmitter; clk, rst_n (async low), enable (freezes shifter), bus.slave (load_valid/din in, load_ready/q/frame/done out)
module piso_shift_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  piso_shift_tx_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic accept, step, last;
  assign accept = bus.load_valid && bus.load_ready;
  assign step = enable && state == SHIFT && cnt != '0;
  // last bit has had its full cycle on q: word completes on this edge
  assign last = enable && state == SHIFT && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? SHIFT : last ? IDLE : state;
  always_comb bus.load_ready = rst_n && enable && (state == IDLE || cnt == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      cnt <= '0;
      bus.q <= 1'b0;
      bus.frame <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= last;
      if (accept) begin
        shreg <= bus.din;
        bus.q <= bus.din[WIDTH-1];
        bus.frame <= 1'b1;
        cnt <= CNT_W'(WIDTH - 1);
      end else if (step) begin
        shreg <= shreg << 1;
        bus.q <= shreg[WIDTH-2];
        cnt <= cnt - CNT_W'(1);
      end else if (last) begin
        bus.q <= 1'b0;
        bus.frame <= 1'b0;
      end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: scoreboard bench for piso_shift_tx; expected bits queued at load, popped as each new bit appears on q
module tb_piso_shift_tx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic exp_q[$];
  logic en_q = 1'b0;
  logic last_bit = 1'b0;

  piso_shift_tx_if #(.WIDTH(W)) bus();
  piso_shift_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.slave));

  always #5 clk = ~clk;

  // a new bit appears on q only after an enabled edge; otherwise the previous bit is stretched
  always @(posedge clk) en_q <= enable;

  always @(negedge clk)
    if (bus.frame === 1'b1) begin
      vectors++;
      if (en_q) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bit: q=%b with frame high but no bit expected", bus.q);
        end else begin
          last_bit = exp_q.pop_front();
          if (bus.q !== last_bit) begin
            errors++;
            $display("FAIL bit @%0t: q=%b expected %b", $time, bus.q, last_bit);
          end
        end
      end else if (bus.q !== last_bit) begin
        errors++;
        $display("FAIL stretch @%0t: q=%b expected held %b", $time, bus.q, last_bit);
      end
    end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b1;
    bus.load_valid = 1'b0;
    bus.din = '0;
    #1;
    vectors++;
    if ({bus.q, bus.frame, bus.done, bus.load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset: q/frame/done/ready=%b expected 0000", {bus.q, bus.frame, bus.done, bus.load_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: load_ready=%b expected 1", bus.load_ready);
    end
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.din = 8'hA5;
    push_word(8'hA5);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.frame, bus.done, bus.load_ready} !== {1'b1, 1'b0, i == W - 1}) begin
        errors++;
        $display("FAIL single[%0d]: frame/done/ready=%b expected %b", i, {bus.frame, bus.done, bus.load_ready}, {1'b1, 1'b0, i == W - 1});
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.frame, bus.done, bus.q} !== 3'b010) begin
      errors++;
      $display("FAIL single_end: frame/done/q=%b expected 010", {bus.frame, bus.done, bus.q});
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.din = 8'hA5;
    push_word(8'hA5);
    @(posedge clk); #1;
    bus.din = 8'h3C;
    push_word(8'h3C);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.frame, bus.done} !== {1'b1, i == W}) begin
        errors++;
        $display("FAIL b2b[%0d]: frame/done=%b expected %b", i, {bus.frame, bus.done}, {1'b1, i == W});
      end
      if (i == W) bus.load_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if ({bus.frame, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_end: frame/done=%b expected 01", {bus.frame, bus.done});
    end
  endtask

  task automatic test_enable_gap;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.din = 8'hF0;
    push_word(8'hF0);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.frame, bus.done} !== 2'b10) begin
        errors++;
        $display("FAIL gap[%0d]: frame/done=%b expected 10", i, {bus.frame, bus.done});
      end
      if (i >= 3 && i <= 5) begin
        vectors++;
        if (bus.load_ready !== 1'b0) begin
          errors++;
          $display("FAIL gap_ready[%0d]: load_ready=%b expected 0", i, bus.load_ready);
        end
      end
      if (i == 2) enable = 1'b0;
      if (i == 5) enable = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if ({bus.frame, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL gap_end: frame/done=%b expected 01", {bus.frame, bus.done});
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_ignores_enable: done=%b expected 0", bus.done);
    end
    enable = 1'b1;
  endtask

  task automatic test_idle_enable;
    @(posedge clk); #1;
    enable = 1'b0;
    bus.load_valid = 1'b1;
    bus.din = 8'h5A;
    #1;
    vectors++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: load_ready=%b expected 0", bus.load_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.q, bus.frame, bus.load_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold: q/frame/ready=%b expected 000", {bus.q, bus.frame, bus.load_ready});
    end
    enable = 1'b1;
    push_word(8'h5A);
    #1;
    vectors++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_enable_ready: load_ready=%b expected 1", bus.load_ready);
    end
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.frame, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL idle_end: frame/done=%b expected 01", {bus.frame, bus.done});
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.din = 8'hFF;
    push_word(8'hFF);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if ({bus.q, bus.frame, bus.done, bus.load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: q/frame/done/ready=%b expected 0000", {bus.q, bus.frame, bus.done, bus.load_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({bus.frame, bus.load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL async_release: frame/ready=%b expected 01", {bus.frame, bus.load_ready});
    end
    bus.load_valid = 1'b1;
    bus.din = 8'h81;
    push_word(8'h81);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < W; i++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.frame, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL async_next_end: frame/done=%b expected 01", {bus.frame, bus.done});
    end
  endtask

  task automatic test_last_bit;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.din = 8'h01;
    push_word(8'h01);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 2 * W + 1; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.frame, bus.done} !== {i < 2 * W, i == W || i == 2 * W}) begin
        errors++;
        $display("FAIL last_bit[%0d]: frame/done=%b expected %b", i, {bus.frame, bus.done}, {i < 2 * W, i == W || i == 2 * W});
      end
      if (i < W - 1) begin
        vectors++;
        if (bus.load_ready !== 1'b0) begin
          errors++;
          $display("FAIL last_bit_ready[%0d]: load_ready=%b expected 0", i, bus.load_ready);
        end
      end
      if (i == W - 1) begin
        bus.load_valid = 1'b1;
        bus.din = 8'hC3;
        push_word(8'hC3);
        vectors++;
        if (bus.load_ready !== 1'b1) begin
          errors++;
          $display("FAIL last_bit_ready_cnt0: load_ready=%b expected 1", bus.load_ready);
        end
      end
      if (i == W) bus.load_valid = 1'b0;
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gap();
    test_idle_enable();
    test_async_reset();
    test_last_bit();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bits never transmitted, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in serial-out transmitter. It serialises a WIDTH-bit word MSB-first onto a single line and is the sending end of the enable-gated D flip-flop serial chain. A valid/ready handshake loads words, and a clock-enable input freezes the shifter exactly as the flip-flop enable does. It drives the serial link feeding the team's SIPO receiver.

Parameters:
WIDTH, 8, word length in bits (>= 2)
CNT_W, $clog2(WIDTH), bit-counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  clock enable; low = hold all shifter state
load_valid  input  1  upstream word available on din
load_ready  output  1  block can accept a word this cycle (combinational)
din  input  WIDTH  parallel word, sampled only on accept
q  output  1  serial data, registered
frame  output  1  high while q carries a valid bit, registered
done  output  1  one-cycle pulse after the last bit of a word leaves

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-word):
  - q=0, frame=0, done=0, shreg=0, cnt=0, state=IDLE.
  - load_ready follows the combinational rule below, so it is 0 while reset is asserted.
  - The current word is discarded; there is no resume.
- States: IDLE, SHIFT.
- load_ready = rst_n & enable & (state==IDLE | (state==SHIFT & cnt==0)).
- Accept = load_valid & load_ready at a rising clk edge. din is ignored at all other times.
- IDLE, on accept:
  - shreg<=din; q<=din[WIDTH-1]; frame<=1; cnt<=WIDTH-1; state<=SHIFT.
- IDLE, no accept: q=0, frame=0, and the block holds.
- SHIFT, enabled edge with cnt>0:
  - shreg shifts left by 1.
  - q<=next bit (the original din[cnt-1]); cnt<=cnt-1.
- SHIFT, enabled edge with cnt==0 (last bit has been on q for one cycle):
  - With accept (back-to-back): load the new word as in IDLE. frame stays 1 with no gap. done<=1.
  - Without accept: state<=IDLE; q<=0; frame<=0; done<=1.
- enable low:
  - No state, shreg, cnt, q or frame change; the current bit is stretched.
  - load_ready=0.
- done:
  - Set only by a completed word, as described above.
  - Cleared on the next rising clk edge, regardless of enable. It is high for exactly one clk cycle.
- Latency, with enable held high:
  - Accept at edge N puts the MSB on q after edge N.
  - Bit i (MSB = 0) is on q after edge N+i; the LSB appears after edge N+WIDTH-1.
  - frame falls and done rises at edge N+WIDTH.
  - The maximum sustained rate is one word per WIDTH cycles.
- Each enable-low cycle inside a word extends that word by one cycle.
- load_valid may drop without an accept; there is no penalty and no state change.
- Counter: cnt is CNT_W bits and decrements only in SHIFT on enabled edges. It never underflows, because cnt==0 always exits or reloads.

Test Plan:
1. Reset, then WIDTH=8, enable=1, load 8'hA5 with one-cycle load_valid -> q = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame high 8 cycles; done high 1 cycle as frame falls; load_ready 0 for cycles 1-7 of shifting and 1 on the 8th.
2. Back-to-back: load_valid held with 8'hA5 then 8'h3C -> 16 contiguous frame cycles; q = 10100101 00111100; done pulses twice, 8 cycles apart; frame never drops between words.
3. Enable gap: load 8'hF0; drop enable for 3 cycles after the 3rd bit -> q holds 1 for 4 cycles; frame high 11 cycles total; done pulses once, at the end.
4. load_valid=1 with enable=0 in IDLE -> load_ready=0; no accept; q=0, frame=0. Raising enable gives an accept on the next edge.
5. Assert rst_n low asynchronously mid-word (after the 4th bit of 8'hFF) -> q, frame and done drop immediately without a clock edge. After release the block is in IDLE and load_ready=1 (enable high). The next word 8'h81 transmits cleanly with no residue from 8'hFF.
6. Last-bit boundary: offer load_valid only in the cnt==0 cycle of 8'h01 -> accepted the same cycle; next word starts with no gap; the done pulse coincides with the new word's first bit.
